// File: rtl/commit_ctrl.sv
// Commit-stage sequencer: in-order retire from the ROB head into the
// RegFile, store handshake with the LSB, and mispredict flush/redirect.
module commit_ctrl #(
  parameter int ROB_IDX_W = 4,
  parameter int REG_IDX_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 head_valid,
  input  logic [ROB_IDX_W-1:0] head_rob_index,
  input  logic [1:0]           head_type,
  input  logic [REG_IDX_W-1:0] head_rd,
  input  logic [XLEN-1:0]      head_value,
  input  logic                 head_mispredict,
  input  logic [XLEN-1:0]      head_target_pc,
  output logic                 head_pop,
  output logic                 rob_enable,
  output logic [REG_IDX_W-1:0] rob_commit_index,
  output logic [ROB_IDX_W-1:0] rob_commit_rename,
  output logic [XLEN-1:0]      rob_commit_value,
  output logic                 store_commit_req,
  output logic [ROB_IDX_W-1:0] store_commit_rob,
  input  logic                 store_done,
  output logic                 jump_wrong,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [31:0]          committed_count
);

  localparam logic [1:0] S_COMMIT = 2'd0;
  localparam logic [1:0] S_SWAIT  = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_NOP    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 en_q, en_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [ROB_IDX_W-1:0] ren_q, ren_d;
  logic [XLEN-1:0]      val_q, val_d;
  logic                 sreq_q, sreq_d;
  logic [ROB_IDX_W-1:0] srob_q, srob_d;
  logic                 jw_q, jw_d;
  logic [XLEN-1:0]      rpc_q, rpc_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 pop;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    idx_d   = idx_q;
    ren_d   = ren_q;
    val_d   = val_q;
    sreq_d  = sreq_q;
    srob_d  = srob_q;
    jw_d    = jw_q;
    rpc_d   = rpc_q;
    pop     = 1'b0;
    // With rdy=0 everything holds, so a pending write is seen exactly once.
    if (rst && rdy) begin
      en_d = 1'b0;
      case (state_q)
        S_COMMIT: begin
          if (head_valid) begin
            case (head_type)
              T_REG: begin
                pop   = 1'b1;
                en_d  = 1'b1;
                idx_d = head_rd;
                ren_d = head_rob_index;
                val_d = head_value;
              end
              T_BRANCH: begin
                pop = 1'b1;
                if (head_rd != '0) begin
                  en_d  = 1'b1;
                  idx_d = head_rd;
                  ren_d = head_rob_index;
                  val_d = head_value;
                end
                if (head_mispredict) begin
                  jw_d    = 1'b1;
                  rpc_d   = head_target_pc;
                  state_d = S_FLUSH;
                end
              end
              T_STORE: begin
                sreq_d  = 1'b1;
                srob_d  = head_rob_index;
                state_d = S_SWAIT;
              end
              T_NOP: pop = 1'b1;
              default: pop = 1'b0;
            endcase
          end
        end
        S_SWAIT: begin
          if (store_done) begin
            pop     = 1'b1;
            sreq_d  = 1'b0;
            state_d = S_COMMIT;
          end
        end
        S_FLUSH: begin
          jw_d    = 1'b0;
          state_d = S_COMMIT;
        end
        default: state_d = S_COMMIT;
      endcase
    end
    cnt_d = cnt_q + {31'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_COMMIT;
      en_q    <= 1'b0;
      idx_q   <= '0;
      ren_q   <= '0;
      val_q   <= '0;
      sreq_q  <= 1'b0;
      srob_q  <= '0;
      jw_q    <= 1'b0;
      rpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      ren_q   <= ren_d;
      val_q   <= val_d;
      sreq_q  <= sreq_d;
      srob_q  <= srob_d;
      jw_q    <= jw_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign head_pop          = pop;
  assign rob_enable        = en_q;
  assign rob_commit_index  = idx_q;
  assign rob_commit_rename = ren_q;
  assign rob_commit_value  = val_q;
  assign store_commit_req  = sreq_q;
  assign store_commit_rob  = srob_q;
  assign jump_wrong        = jw_q;
  assign redirect_pc       = rpc_q;
  assign committed_count   = cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: directed vector table plus randomized run
// against a reference model of the retire rules.
module tb_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, head_valid, head_mispredict, store_done;
  logic [3:0]  head_rob_index;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic [31:0] head_value, head_target_pc;
  logic        head_pop, rob_enable, store_commit_req, jump_wrong;
  logic [4:0]  rob_commit_index;
  logic [3:0]  rob_commit_rename, store_commit_rob;
  logic [31:0] rob_commit_value, redirect_pc, committed_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_ctrl #(.ROB_IDX_W(4), .REG_IDX_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .head_valid(head_valid), .head_rob_index(head_rob_index),
    .head_type(head_type), .head_rd(head_rd),
    .head_value(head_value), .head_mispredict(head_mispredict),
    .head_target_pc(head_target_pc), .head_pop(head_pop),
    .rob_enable(rob_enable), .rob_commit_index(rob_commit_index),
    .rob_commit_rename(rob_commit_rename),
    .rob_commit_value(rob_commit_value),
    .store_commit_req(store_commit_req),
    .store_commit_rob(store_commit_rob), .store_done(store_done),
    .jump_wrong(jump_wrong), .redirect_pc(redirect_pc),
    .committed_count(committed_count)
  );

  typedef struct {
    logic        rst, rdy, hv;
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  tag;
    logic        mis;
    logic [31:0] tpc;
    logic        sd;
    logic        e_pop, e_en;
    logic [4:0]  e_idx;
    logic [31:0] e_val;
    logic [3:0]  e_ren;
    logic        e_sreq;
    logic [3:0]  e_srob;
    logic        e_jw;
    logic [31:0] e_rpc;
    logic [31:0] e_cnt;
    logic        all;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic y, input logic hv,
                       input logic [1:0] ty, input logic [4:0] rd,
                       input logic [31:0] val, input logic [3:0] tag,
                       input logic mis, input logic [31:0] tpc,
                       input logic sd);
    rst = r; rdy = y; head_valid = hv; head_type = ty; head_rd = rd;
    head_value = val; head_rob_index = tag; head_mispredict = mis;
    head_target_pc = tpc; store_done = sd;
  endtask

  function automatic vec_t v(
    input logic r, y, hv, input logic [1:0] ty, input logic [4:0] rd,
    input logic [31:0] val, input logic [3:0] tag, input logic mis,
    input logic [31:0] tpc, input logic sd, input logic ep, ee,
    input logic [4:0] ei, input logic [31:0] ev, input logic [3:0] er,
    input logic es, input logic [3:0] esr, input logic ej,
    input logic [31:0] erp, input logic [31:0] ec, input logic all);
    vec_t t;
    t.rst = r; t.rdy = y; t.hv = hv; t.ty = ty; t.rd = rd; t.val = val;
    t.tag = tag; t.mis = mis; t.tpc = tpc; t.sd = sd; t.e_pop = ep;
    t.e_en = ee; t.e_idx = ei; t.e_val = ev; t.e_ren = er; t.e_sreq = es;
    t.e_srob = esr; t.e_jw = ej; t.e_rpc = erp; t.e_cnt = ec; t.all = all;
    return t;
  endfunction

  vec_t tbl[$];

  // reference model state
  int          m_mode;
  logic        m_en, m_sreq, m_jw;
  logic [4:0]  m_idx;
  logic [3:0]  m_ren, m_srob;
  logic [31:0] m_val, m_rpc, m_cnt;

  task automatic model_reset();
    m_mode = 0; m_en = 0; m_sreq = 0; m_jw = 0; m_idx = 0;
    m_ren = 0; m_srob = 0; m_val = 0; m_rpc = 0; m_cnt = 0;
  endtask

  function automatic logic model_pop();
    if (!rst || !rdy) return 1'b0;
    if (m_mode == 0) return head_valid && head_type != 2'd1;
    if (m_mode == 1) return store_done;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic pop);
    bit writes;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    m_cnt += pop ? 32'd1 : 32'd0;
    writes = (m_mode == 0) && head_valid &&
             (head_type == 2'd0 || (head_type == 2'd2 && head_rd != 0));
    m_en = writes;
    if (writes) begin
      m_idx = head_rd; m_ren = head_rob_index; m_val = head_value;
    end
    case (m_mode)
      0: if (head_valid && head_type == 2'd1) begin
           m_sreq = 1; m_srob = head_rob_index; m_mode = 1;
         end else if (head_valid && head_type == 2'd2 && head_mispredict) begin
           m_jw = 1; m_rpc = head_target_pc; m_mode = 2;
         end
      1: if (store_done) begin m_sreq = 0; m_mode = 0; end
      default: begin m_jw = 0; m_mode = 0; end
    endcase
  endtask

  task automatic chk_model();
    chk("r_en", rob_enable, m_en);
    if (m_en) begin
      chk("r_idx", rob_commit_index, m_idx);
      chk("r_ren", rob_commit_rename, m_ren);
      chk("r_val", rob_commit_value, m_val);
    end
    chk("r_sreq", store_commit_req, m_sreq);
    if (m_sreq) chk("r_srob", store_commit_rob, m_srob);
    chk("r_jw", jump_wrong, m_jw);
    if (m_jw) chk("r_rpc", redirect_pc, m_rpc);
    chk("r_cnt", committed_count, m_cnt);
  endtask

  initial begin
    logic p;
    drive(0, 1, 1, 0, 5, 32'h11, 1, 0, 0, 0);
    // reset with a valid head
    tbl.push_back(v(0,1,1,0,5,'h11,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(v(0,1,1,0,5,'h11,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,1));
    // back-to-back REG
    tbl.push_back(v(1,1,1,0,5,'h11,1,0,0,0, 1,1,5,'h11,1,0,0,0,0,1,0));
    tbl.push_back(v(1,1,1,0,6,'h22,2,0,0,0, 1,1,6,'h22,2,0,0,0,0,2,0));
    tbl.push_back(v(1,1,1,0,7,'h33,3,0,0,0, 1,1,7,'h33,3,0,0,0,0,3,0));
    // store, ack 3 cycles after request
    tbl.push_back(v(1,1,1,1,0,0,4,0,0,0, 0,0,0,0,0,1,4,0,0,3,0));
    tbl.push_back(v(1,1,1,1,0,0,4,0,0,0, 0,0,0,0,0,1,4,0,0,3,0));
    tbl.push_back(v(1,1,1,1,0,0,4,0,0,0, 0,0,0,0,0,1,4,0,0,3,0));
    tbl.push_back(v(1,1,1,1,0,0,4,0,0,1, 1,0,0,0,0,0,0,0,0,4,0));
    tbl.push_back(v(1,1,1,0,8,'h44,5,0,0,0, 1,1,8,'h44,5,0,0,0,0,5,0));
    // mispredict, then rdy low for 2 cycles
    tbl.push_back(v(1,1,1,2,0,0,9,1,'h1000,0, 1,0,0,0,0,0,0,1,'h1000,6,0));
    tbl.push_back(v(1,0,1,0,9,'h99,1,0,0,0, 0,0,0,0,0,0,0,1,'h1000,6,0));
    tbl.push_back(v(1,0,1,0,9,'h99,1,0,0,0, 0,0,0,0,0,0,0,1,'h1000,6,0));
    tbl.push_back(v(1,1,1,0,9,'h99,1,0,0,0, 0,0,0,0,0,0,0,0,0,6,0));
    // rdy stall right after a REG accept
    tbl.push_back(v(1,1,1,0,10,'hAA,6,0,0,0, 1,1,10,'hAA,6,0,0,0,0,7,0));
    tbl.push_back(v(1,0,1,0,11,'hBB,7,0,0,0, 0,1,10,'hAA,6,0,0,0,0,7,0));
    tbl.push_back(v(1,0,1,0,11,'hBB,7,0,0,0, 0,1,10,'hAA,6,0,0,0,0,7,0));
    tbl.push_back(v(1,1,0,0,11,'hBB,7,0,0,0, 0,0,0,0,0,0,0,0,0,7,0));
    // reset during STORE_WAIT, then a late ack
    tbl.push_back(v(1,1,1,1,0,0,7,0,0,0, 0,0,0,0,0,1,7,0,0,7,0));
    tbl.push_back(v(0,1,0,1,0,0,7,0,0,0, 0,0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(v(1,1,0,1,0,0,7,0,0,1, 0,0,0,0,0,0,0,0,0,0,0));
    // correct BRANCH with rd, NOP, REG to x0
    tbl.push_back(v(1,1,1,2,3,'h55,8,0,'h2000,0, 1,1,3,'h55,8,0,0,0,0,1,0));
    tbl.push_back(v(1,1,1,3,4,'h77,9,0,0,0, 1,0,0,0,0,0,0,0,0,2,0));
    tbl.push_back(v(1,1,1,0,0,'h66,10,0,0,0, 1,1,0,'h66,10,0,0,0,0,3,0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      drive(t.rst, t.rdy, t.hv, t.ty, t.rd, t.val, t.tag, t.mis, t.tpc, t.sd);
      #1;
      chk($sformatf("v%0d_pop", i), head_pop, t.e_pop);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), rob_enable, t.e_en);
      if (t.e_en || t.all) begin
        chk($sformatf("v%0d_idx", i), rob_commit_index, t.e_idx);
        chk($sformatf("v%0d_val", i), rob_commit_value, t.e_val);
        chk($sformatf("v%0d_ren", i), rob_commit_rename, t.e_ren);
      end
      chk($sformatf("v%0d_sreq", i), store_commit_req, t.e_sreq);
      if (t.e_sreq || t.all)
        chk($sformatf("v%0d_srob", i), store_commit_rob, t.e_srob);
      chk($sformatf("v%0d_jw", i), jump_wrong, t.e_jw);
      if (t.e_jw || t.all)
        chk($sformatf("v%0d_rpc", i), redirect_pc, t.e_rpc);
      chk($sformatf("v%0d_cnt", i), committed_count, t.e_cnt);
    end

    // randomized run against the model, starting from a reset
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), $urandom,
            ($urandom_range(0, 2) == 0));
      #1;
      p = model_pop();
      chk("r_pop", head_pop, p);
      @(posedge clk);
      model_edge(p);
      #1;
      chk_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Commit-stage sequencer between the ROB head and the architectural RegFile write port.
- Retires at most one ROB entry per cycle in order:
  - register-writing entries drive the RegFile commit interface;
  - stores are held until the LSB acknowledges;
  - a mispredicted branch triggers the global jump_wrong flush and a PC redirect.
- Sole producer of rob_enable / rob_commit_* and of jump_wrong.

Parameters:
- ROB_IDX_W, 4, width of a ROB index (rename tag)
- REG_IDX_W, 5, width of an architectural register index
- XLEN, 32, data/PC width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge)
- rdy  in  1  global ready; 0 = freeze
- head_valid  in  1  ROB head entry is complete and ready to retire
- head_rob_index  in  ROB_IDX_W  ROB index of head entry
- head_type  in  2  00 REG, 01 STORE, 10 BRANCH, 11 NOP
- head_rd  in  REG_IDX_W  destination register of head
- head_value  in  XLEN  result value (link value for BRANCH)
- head_mispredict  in  1  BRANCH head was mispredicted
- head_target_pc  in  XLEN  correct PC for a mispredicted BRANCH
- head_pop  out  1  combinational; ROB advances head on this edge
- rob_enable  out  1  RegFile commit strobe
- rob_commit_index  out  REG_IDX_W  register written
- rob_commit_rename  out  ROB_IDX_W  ROB tag of committing entry
- rob_commit_value  out  XLEN  value written
- store_commit_req  out  1  request LSB to perform head store
- store_commit_rob  out  ROB_IDX_W  ROB tag of that store
- store_done  in  1  LSB finished the requested store
- jump_wrong  out  1  global flush
- redirect_pc  out  XLEN  fetch redirect target, valid while jump_wrong=1
- committed_count  out  32  retired-instruction counter

Behaviour:
- Reset (rst==0 at a clk edge, regardless of rdy or state):
  - state=COMMIT;
  - all registered outputs 0 (rob_enable, rob_commit_*, store_commit_req, store_commit_rob, jump_wrong, redirect_pc, committed_count);
  - head_pop=0 while rst==0.
- States: COMMIT, STORE_WAIT, FLUSH.
- Accept condition: accept = rst && rdy && state==COMMIT && head_valid.
- COMMIT, by head_type when accept:
  - REG: head_pop=1. Next edge: rob_enable=1, index=head_rd, rename=head_rob_index, value=head_value. rd==0 still commits; RegFile discards x0.
  - NOP: head_pop=1, no RegFile write.
  - BRANCH, head_mispredict=0: head_pop=1. If head_rd!=0, RegFile write as REG.
  - BRANCH, head_mispredict=1: head_pop=1, plus the rd write as above. Next edge: jump_wrong=1, redirect_pc=head_target_pc, state=FLUSH.
  - STORE: head_pop=0. Next edge: store_commit_req=1, store_commit_rob=head_rob_index, state=STORE_WAIT.
- STORE_WAIT:
  - store_commit_req held 1.
  - When rdy && store_done: head_pop=1. Next edge: store_commit_req=0, state=COMMIT.
  - store_done while rdy=0 is ignored; LSB must hold store_done until it is consumed.
- FLUSH:
  - jump_wrong and redirect_pc held.
  - First edge with rdy=1: jump_wrong=0, state=COMMIT.
  - No pops in FLUSH; the ROB and RegFile clear themselves on the jump_wrong edge.
- rob_enable pulse rule:
  - Set on an accepting edge.
  - Cleared on the next edge with rdy=1 unless a new REG/BRANCH-rd commit is accepted; back-to-back commits keep it 1 with new fields.
  - Held unchanged through rdy=0 cycles, so the RegFile always consumes each write exactly once.
- rdy=0: state, counters and all registered outputs hold; head_pop=0.
- Throughput: 1 retire/cycle for REG/NOP/BRANCH.
- Store cost: ≥2 cycles (request edge, then ack cycle).
- committed_count: +1 on every edge where head_pop=1; wraps modulo 2^32; unaffected by jump_wrong.
- Mispredict flush order: the mispredicting branch's own rd write is issued on the same edge jump_wrong rises. RegFile gives jump_wrong priority, so the link value is lost; the ROB must not mark BRANCH heads with rd!=0 as mispredicted-with-link. Branches with a link register retire via a REG entry first.

Test Plan:
- Reset: rst=0 for 2 cycles with head_valid=1 -> head_pop=0; all outputs 0; committed_count=0.
- Back-to-back REG: 3 heads rd=5,6,7, values 0x11,0x22,0x33, tags 1,2,3, rdy=1 -> head_pop high 3 consecutive cycles; rob_enable high 3 cycles with matching index/rename/value; committed_count=3.
- Store: STORE tag 4, store_done asserted 3 cycles after req -> store_commit_req=1, store_commit_rob=4 until ack; head_pop=1 only in the ack cycle; next head retires the following cycle.
- Mispredict: BRANCH tag 9, mispredict=1, target 0x1000, rdy dropped the cycle after acceptance for 2 cycles -> jump_wrong=1, redirect_pc=0x1000 held 3 cycles, clears on the first rdy=1 edge; no pops meanwhile.
- rdy stall on REG: rdy=0 for 2 cycles right after acceptance -> rob_enable stays 1 with unchanged fields, then drops after one rdy=1 edge; count increments once.
- Reset mid-STORE_WAIT: rst=0 while store_commit_req=1 -> next edge state=COMMIT, store_commit_req=0; a late store_done is ignored.
